// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button conditioning stage: arbitration FSM
// states, the colour codes used by the button latch and by software, and a
// small helper that turns a button vector into its colour code.
package button_debounce_pkg;

    localparam int NUM_BUTTONS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    typedef logic [1:0] code_t;

    // Bit positions in every button vector follow these codes.
    localparam code_t CODE_RED    = 2'b00;
    localparam code_t CODE_BLUE   = 2'b01;
    localparam code_t CODE_GREEN  = 2'b10;
    localparam code_t CODE_YELLOW = 2'b11;

    // Code of the lowest-numbered high button; only used on one-hot vectors.
    function automatic code_t encodeButton(input logic [NUM_BUTTONS-1:0] v);
        code_t c;
        c = CODE_RED;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (v[i]) c = code_t'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle between the raw push buttons and the conditioning stage.
// The slave side is the debouncer; the master side drives the raw inputs
// and consumes the clean levels and press events.
interface button_debounce_if;
    import button_debounce_pkg::*;

    logic  red_raw;
    logic  blue_raw;
    logic  green_raw;
    logic  yellow_raw;
    logic  red_out;
    logic  blue_out;
    logic  green_out;
    logic  yellow_out;
    logic  press_pulse;
    code_t press_code;

    modport master (
        output red_raw, blue_raw, green_raw, yellow_raw,
        input  red_out, blue_out, green_out, yellow_out, press_pulse, press_code
    );

    modport slave (
        input  red_raw, blue_raw, green_raw, yellow_raw,
        output red_out, blue_out, green_out, yellow_out, press_pulse, press_code
    );

endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchronizer followed by a counter that flips
// the stable level only after DEBOUNCE_CYCLES consecutive disagreeing edges.
module debounce_channel #(
    parameter int  DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing edges; any agreeing edge or an accepted flip restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce counter and stable level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/button_debounce.sv
// Button conditioning stage: debounces the four raw buttons and arbitrates
// them so the downstream latch sees at most one clean level at a time, plus
// a one-cycle press strobe and the colour code of the last accepted press.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clock,
    input  logic               resetn,
    button_debounce_if.slave   bus
);

    logic [NUM_BUTTONS-1:0] rawVec;
    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] others;
    logic [NUM_BUTTONS-1:0] outs_q;
    logic [NUM_BUTTONS-1:0] outs_d;
    state_e                 state_q;
    state_e                 state_d;
    code_t                  code_q;
    code_t                  code_d;
    logic                   pulse_q;
    logic                   pulse_d;

    assign rawVec = {bus.yellow_raw, bus.green_raw, bus.blue_raw, bus.red_raw};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gChannel
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uChannel (
            .clk     (clock),
            .rst_n   (resetn),
            .raw_i   (rawVec[i]),
            .stable_o(stable[i])
        );
    end

    // Arbitration: accept a lone press, block ties and overlaps until all buttons are released.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        others  = stable & ~(NUM_BUTTONS'(1) << code_q);
        case (state_q)
            ST_IDLE: begin
                if ($countones(stable) == 1) begin
                    state_d = ST_LOCKED;
                    code_d  = encodeButton(stable);
                    pulse_d = 1'b1;
                end else if ($countones(stable) > 1) begin
                    state_d = ST_BLOCKED;
                end
            end
            ST_LOCKED: begin
                if (!stable[code_q]) begin
                    state_d = (others != '0) ? ST_BLOCKED : ST_IDLE;
                end
            end
            ST_BLOCKED: begin
                if (stable == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        outs_d = (state_d == ST_LOCKED) ? (NUM_BUTTONS'(1) << code_d) : '0;
    end

    // State and registered outputs, so the levels and strobe rise on the accepting edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            code_q  <= CODE_RED;
            outs_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            outs_q  <= outs_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.red_out     = outs_q[CODE_RED];
    assign bus.blue_out    = outs_q[CODE_BLUE];
    assign bus.green_out   = outs_q[CODE_GREEN];
    assign bus.yellow_out  = outs_q[CODE_YELLOW];
    assign bus.press_pulse = pulse_q;
    assign bus.press_code  = code_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a short debounce window. A
// window-based behavioural model predicts every output each cycle; literal
// checks at the hand-computed edges pin both the DUT and the model.
module tb_button_debounce;
    import button_debounce_pkg::*;

    localparam int DB = 4;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] rawVec = 4'b0000;

    int checks    = 0;
    int failures  = 0;
    int dutPulses = 0;

    button_debounce_if bus ();

    assign bus.red_raw    = rawVec[0];
    assign bus.blue_raw   = rawVec[1];
    assign bus.green_raw  = rawVec[2];
    assign bus.yellow_raw = rawVec[3];

    button_debounce #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model state: raw history per button, stable levels, arbitration mode.
    logic [DB:0] hist [4];
    logic [3:0]  mStable;
    int          mMode;
    int          mSel;
    logic [3:0]  mOut;
    logic        mPulse;
    logic [1:0]  mCode;

    function automatic logic [3:0] dutOuts();
        return {bus.yellow_out, bus.green_out, bus.blue_out, bus.red_out};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a button's stable level flips once its last DB synchronized samples
    // (raw as seen two edges earlier) all disagree with it; arbitration follows
    // the accept / ignore / block rules on the previous stable levels.
    always @(posedge clock or negedge resetn) begin : modelStep
        logic [3:0] st;
        int         nHigh;
        bit         allDiffer;
        if (!resetn) begin
            for (int c = 0; c < 4; c++) hist[c] = '0;
            mStable = 4'b0000;
            mMode   = 0;
            mSel    = 0;
            mOut    = 4'b0000;
            mPulse  = 1'b0;
            mCode   = 2'b00;
        end else begin
            st     = mStable;
            nHigh  = $countones(st);
            mPulse = 1'b0;
            if (mMode == 0) begin
                if (nHigh == 1) begin
                    for (int c = 0; c < 4; c++) if (st[c]) mSel = c;
                    mMode  = 1;
                    mPulse = 1'b1;
                    mCode  = 2'(mSel);
                end else if (nHigh > 1) begin
                    mMode = 2;
                end
            end else if (mMode == 1) begin
                if (!st[mSel]) mMode = (nHigh > 0) ? 2 : 0;
            end else begin
                if (nHigh == 0) mMode = 0;
            end
            mOut = (mMode == 1) ? (4'b0001 << mSel) : 4'b0000;
            for (int c = 0; c < 4; c++) begin
                allDiffer = 1'b1;
                for (int j = 1; j <= DB; j++) if (hist[c][j] == st[c]) allDiffer = 1'b0;
                if (allDiffer) mStable[c] = ~st[c];
                for (int j = DB; j >= 1; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = rawVec[c];
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, plus the one-hot invariant.
    always @(negedge clock) begin
        if (resetn) begin
            checkOutput("outs_vs_model", int'(dutOuts()), int'(mOut));
            checkOutput("pulse_vs_model", int'(bus.press_pulse), int'(mPulse));
            checkOutput("code_vs_model", int'(bus.press_code), int'(mCode));
            checkOutput("outs_onehot", int'($countones(dutOuts()) <= 1), 1);
            if (bus.press_pulse) dutPulses++;
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input int n);
        @(negedge clock);
        rawVec = v;
        repeat (n) @(posedge clock);
    endtask

    // Literal expectation on the DUT, mirrored against the model as well.
    task automatic checkNow(input string tag, input logic [3:0] outs, input logic pulse, input int code);
        checkOutput({tag, "_outs"}, int'(dutOuts()), int'(outs));
        checkOutput({tag, "_pulse"}, int'(bus.press_pulse), int'(pulse));
        checkOutput({tag, "_model_outs"}, int'(mOut), int'(outs));
        if (code >= 0) begin
            checkOutput({tag, "_code"}, int'(bus.press_code), code);
            checkOutput({tag, "_model_code"}, int'(mCode), code);
        end
    endtask

    // Raw level applied before edge k: nothing through edge k+5, accepted at edge k+6.
    task automatic pressAndExpect(input string tag, input logic [3:0] v, input int idx, input int code);
        applyStimulus(v, 6);
        #1 checkNow({tag, "_before"}, 4'b0000, 1'b0, -1);
        @(posedge clock);
        #1 checkNow({tag, "_accept"}, 4'b0001 << idx, 1'b1, code);
        @(posedge clock);
        #1 checkNow({tag, "_hold"}, 4'b0001 << idx, 1'b0, code);
    endtask

    initial begin : stimulus
        int p0;
        repeat (3) @(posedge clock);
        #1 checkNow("reset", 4'b0000, 1'b0, 0);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(4'b0000, 4);

        // Clean press and release of red.
        p0 = dutPulses;
        pressAndExpect("clean_red", 4'b0001, 0, 0);
        applyStimulus(4'b0000, 10);
        #1 checkNow("red_released", 4'b0000, 1'b0, 0);
        checkOutput("clean_pulse_count", dutPulses - p0, 1);

        // Bounce on blue, then steady.
        p0 = dutPulses;
        applyStimulus(4'b0010, 1);
        applyStimulus(4'b0000, 1);
        applyStimulus(4'b0010, 1);
        applyStimulus(4'b0000, 1);
        #1 checkNow("bouncing", 4'b0000, 1'b0, -1);
        pressAndExpect("bounce_blue", 4'b0010, 1, 1);
        applyStimulus(4'b0000, 10);
        checkOutput("bounce_pulse_count", dutPulses - p0, 1);

        // Simultaneous green and yellow block; yellow alone is then accepted.
        p0 = dutPulses;
        applyStimulus(4'b1100, 12);
        #1 checkNow("simultaneous", 4'b0000, 1'b0, 1);
        applyStimulus(4'b0000, 10);
        checkOutput("simultaneous_pulse_count", dutPulses - p0, 0);
        pressAndExpect("yellow_alone", 4'b1000, 3, 3);
        applyStimulus(4'b0000, 10);

        // Overlap: red locked, blue pressed and held past red's release.
        pressAndExpect("overlap_red", 4'b0001, 0, 0);
        p0 = dutPulses;
        applyStimulus(4'b0011, 8);
        #1 checkNow("overlap_both", 4'b0001, 1'b0, 0);
        applyStimulus(4'b0010, 10);
        #1 checkNow("overlap_blue_held", 4'b0000, 1'b0, 0);
        applyStimulus(4'b0000, 10);
        checkOutput("overlap_pulse_count", dutPulses - p0, 0);
        pressAndExpect("blue_again", 4'b0010, 1, 1);
        applyStimulus(4'b0000, 10);

        // Code persists after release.
        pressAndExpect("green", 4'b0100, 2, 2);
        applyStimulus(4'b0000, 10);
        #1 checkNow("green_released", 4'b0000, 1'b0, 2);

        // Reset while red is locked, red still held afterwards.
        pressAndExpect("pre_reset_red", 4'b0001, 0, 0);
        repeat (2) @(posedge clock);
        #2 resetn = 1'b0;
        #1 checkNow("in_reset", 4'b0000, 1'b0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        p0 = dutPulses;
        repeat (6) @(posedge clock);
        #1 checkNow("post_reset_before", 4'b0000, 1'b0, 0);
        @(posedge clock);
        #1 checkNow("post_reset_accept", 4'b0001, 1'b1, 0);
        applyStimulus(4'b0000, 10);
        checkOutput("post_reset_pulse_count", dutPulses - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
